// File: rtl/threebitcounter_driver.sv
// Command sequencer driving the three-bit counter's ld/inc/data_in.
// Keeps a shadow count, never increments past 7, flags counter divergence.
module threebitcounter_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_arg,
    output logic       ld,
    output logic       inc,
    output logic [2:0] data_in,
    input  logic [2:0] data_out,
    output logic       done,
    output logic       sat,
    output logic       mismatch,
    output logic [2:0] shadow
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_INC,
        S_ACK
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] remaining;
    logic [2:0] load_val;
    logic       armed;
    logic       accept;
    logic       at_top;

    assign accept = cmd_valid && (state == S_IDLE);
    assign at_top = (shadow == 3'd7);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_LOAD:  state_nx = S_LOAD;
                        OP_CLEAR: state_nx = S_LOAD;
                        OP_INC:   state_nx = (cmd_arg != 3'd0) ? S_INC : S_ACK;
                        OP_NOP:   state_nx = S_ACK;
                    endcase
                end
            end
            S_LOAD: state_nx = S_IDLE;
            S_INC: begin
                if (at_top || remaining == 3'd1) begin
                    state_nx = S_IDLE;
                end
            end
            S_ACK:  state_nx = S_IDLE;
        endcase
    end

    // Datapath: load value, burst length, shadow count and divergence check.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow    <= 3'd0;
            remaining <= 3'd0;
            load_val  <= 3'd0;
            armed     <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            if (armed && data_out != shadow) begin
                mismatch <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd_op == OP_LOAD) begin
                            load_val <= cmd_arg;
                        end else if (cmd_op == OP_CLEAR) begin
                            load_val <= 3'd0;
                        end else if (cmd_op == OP_INC) begin
                            remaining <= cmd_arg;
                        end
                    end
                end
                S_LOAD: begin
                    shadow <= load_val;
                    armed  <= 1'b1;
                end
                S_INC: begin
                    if (at_top) begin
                        remaining <= 3'd0;
                    end else begin
                        shadow    <= shadow + 3'd1;
                        remaining <= remaining - 3'd1;
                    end
                end
                S_ACK: begin
                end
            endcase
        end
    end

    // Strobes decoded from registered state, forced quiet while in reset.
    always_comb begin
        cmd_ready = (state == S_IDLE) || !rst;
        ld        = rst && (state == S_LOAD);
        inc       = rst && (state == S_INC) && !at_top;
        sat       = rst && (state == S_INC) && at_top;
        data_in   = rst ? load_val : 3'd0;
        done      = 1'b0;
        if (rst) begin
            unique case (state)
                S_IDLE: done = 1'b0;
                S_LOAD: done = 1'b1;
                S_INC:  done = at_top || (remaining == 3'd1);
                S_ACK:  done = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_threebitcounter_driver.sv
// Randomized bench for threebitcounter_driver with a command-level model
// that expands each accepted command into its per-cycle output schedule.
module tb_threebitcounter_driver;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_arg;
    logic       ld;
    logic       inc;
    logic [2:0] data_in;
    logic [2:0] data_out;
    logic       done;
    logic       sat;
    logic       mismatch;
    logic [2:0] shadow;

    logic [2:0] cnt;
    logic       fault;
    logic [2:0] fault_val;

    int checks = 0;
    int failures = 0;
    int inc_cnt = 0;
    int sat_cnt = 0;
    int done_cnt = 0;

    threebitcounter_driver dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_arg(cmd_arg),
        .ld(ld),
        .inc(inc),
        .data_in(data_in),
        .data_out(data_out),
        .done(done),
        .sat(sat),
        .mismatch(mismatch),
        .shadow(shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The counter being driven, with an optional fault override.
    always @(posedge clk) begin
        if (!rst) cnt <= 3'd0;
        else if (ld) cnt <= data_in;
        else if (inc) cnt <= cnt + 3'd1;
    end
    assign data_out = fault ? fault_val : cnt;

    typedef struct {
        bit ld;
        bit inc;
        bit done;
        bit sat;
        int din;
        int sh;
        int nxt;
        bit arm;
    } exp_t;

    exp_t q[$];
    int   msh = 0;
    int   mlv = 0;
    bit   marm = 0;
    bit   mmm = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(bit l, bit i, bit d, bit s,
                                int din, int sh, int nxt, bit arm);
        exp_t e;
        e.ld = l; e.inc = i; e.done = d; e.sat = s;
        e.din = din; e.sh = sh; e.nxt = nxt; e.arm = arm;
        return e;
    endfunction

    // Expand an accepted command into expected cycles.
    task automatic expand(input int op, input int arg);
        int s;
        int k;
        s = msh;
        case (op)
            1: begin
                mlv = arg;
                q.push_back(mk(1, 0, 1, 0, arg, s, arg, 1));
            end
            3: begin
                mlv = 0;
                q.push_back(mk(1, 0, 1, 0, 0, s, 0, 1));
            end
            2: begin
                if (arg == 0) begin
                    q.push_back(mk(0, 0, 1, 0, mlv, s, s, 0));
                end else begin
                    k = (arg < 7 - s) ? arg : 7 - s;
                    for (int j = 1; j <= k; j++)
                        q.push_back(mk(0, 1, j == arg, 0, mlv, s + j - 1, s + j, 0));
                    if (s + arg > 7)
                        q.push_back(mk(0, 0, 1, 1, mlv, 7, 7, 0));
                end
            end
            default: q.push_back(mk(0, 0, 1, 0, mlv, s, s, 0));
        endcase
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        exp_t e;
        bit rdy;
        if (inc) inc_cnt++;
        if (sat) sat_cnt++;
        if (done) done_cnt++;
        chk("inc_at_7", int'(inc && data_out == 3'd7), 0);
        if (!rst) begin
            chk("rst_ld", int'(ld), 0);
            chk("rst_inc", int'(inc), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_sat", int'(sat), 0);
            chk("rst_data_in", int'(data_in), 0);
            q.delete();
            msh = 0; mlv = 0; marm = 0; mmm = 0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                rdy = 0;
            end else begin
                e = mk(0, 0, 0, 0, mlv, msh, msh, 0);
                rdy = 1;
            end
            chk("ld", int'(ld), int'(e.ld));
            chk("inc", int'(inc), int'(e.inc));
            chk("done", int'(done), int'(e.done));
            chk("sat", int'(sat), int'(e.sat));
            chk("data_in", int'(data_in), e.din);
            chk("shadow", int'(shadow), e.sh);
            chk("cmd_ready", int'(cmd_ready), int'(rdy));
            chk("mismatch", int'(mismatch), int'(mmm));
            if (marm && int'(data_out) != e.sh) mmm = 1;
            msh = e.nxt;
            if (e.arm) marm = 1;
            if (rdy && cmd_valid) expand(int'(cmd_op), int'(cmd_arg));
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] arg, input bit keep);
        bit acc;
        acc = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_arg = arg;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready && rst;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = cmd_ready;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int i0;
        int s0;
        int d0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_arg = 3'd0;
        fault = 1'b0;
        fault_val = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_shadow", int'(shadow), 0);
        chk("reset_ready", int'(cmd_ready), 1);

        // LOAD 5 then INC 2
        send(2'b01, 3'd5, 0);
        wait_idle();
        i0 = inc_cnt; s0 = sat_cnt;
        send(2'b10, 3'd2, 0);
        wait_idle();
        chk("l5i2_inc_cycles", inc_cnt - i0, 2);
        chk("l5i2_sat", sat_cnt - s0, 0);
        chk("l5i2_shadow", int'(shadow), 7);

        // LOAD 5 then INC 6
        send(2'b01, 3'd5, 0);
        wait_idle();
        i0 = inc_cnt; s0 = sat_cnt;
        send(2'b10, 3'd6, 0);
        wait_idle();
        chk("l5i6_inc_cycles", inc_cnt - i0, 2);
        chk("l5i6_sat", sat_cnt - s0, 1);
        chk("l5i6_shadow", int'(shadow), 7);

        // CLEAR after count 6
        send(2'b01, 3'd4, 0);
        send(2'b10, 3'd2, 0);
        wait_idle();
        chk("pre_clear_shadow", int'(shadow), 6);
        send(2'b11, 3'd5, 0);
        wait_idle();
        chk("clear_shadow", int'(shadow), 0);
        chk("clear_data_out", int'(data_out), 0);

        // NOP then INC 0 with valid held
        d0 = done_cnt; i0 = inc_cnt;
        send(2'b00, 3'd3, 1);
        send(2'b10, 3'd0, 0);
        wait_idle();
        chk("hold_done", done_cnt - d0, 2);
        chk("hold_inc", inc_cnt - i0, 0);

        // Divergence detection
        send(2'b01, 3'd3, 0);
        wait_idle();
        chk("pre_fault_mismatch", int'(mismatch), 0);
        fault = 1'b1;
        fault_val = 3'd4;
        @(posedge clk);
        #1 fault = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("fault_mismatch", int'(mismatch), 1);

        // Reset in the middle of an INC burst
        send(2'b01, 3'd0, 0);
        wait_idle();
        send(2'b10, 3'd7, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_shadow", int'(shadow), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_mismatch", int'(mismatch), 0);
        chk("midrst_inc", int'(inc), 0);
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0);
            if (!cmd_valid) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        chk("final_mismatch", int'(mismatch), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
